seq_serializer: RTL and testbench

SEQ_SERIALIZER -- requirements
Module: seq_serializer

---
 rtl/seq_serializer.sv | 85 ++++++++
 tb/tb_seq_serializer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/seq_serializer.sv
// Parallel-to-serial frame converter feeding a downstream sequence detector.
// Optional macro SEQ_SER_PARITY_EN appends an even-parity bit after the data bits.
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             t,
  output logic             t_valid,
  output logic             t_last
);

`ifdef SEQ_SER_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  shreg, shreg_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0]  frame;
  logic          xfer;

  // The outgoing bit always sits at the end of shreg that the shift empties from,
  // so the parity bit is placed at the opposite end to land after the data.
`ifdef SEQ_SER_PARITY_EN
  assign frame = MSB_FIRST ? {din, ^din} : {^din, din};
`else
  assign frame = din;
`endif

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    din_ready = 1'b0;
    t         = 1'b0;
    t_valid   = 1'b0;
    t_last    = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        din_ready = 1'b1;
      end
      SHIFT: begin
        t_valid   = 1'b1;
        t         = MSB_FIRST ? shreg[N-1] : shreg[0];
        t_last    = (cnt == LAST);
        din_ready = t_last;
        shreg_nxt = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
        cnt_nxt   = cnt + 1'b1;
        if (t_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    xfer = din_valid & din_ready;
    if (xfer) begin
      state_nxt = SHIFT;
      shreg_nxt = frame;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: MSB-first and LSB-first instances share stimulus and
// are checked every cycle against a queue-of-bits frame model.
module tb_seq_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         din_valid = 1'b0;
  logic [W-1:0] din = '0;

  logic ready_m, t_m, valid_m, last_m;
  logic ready_l, t_l, valid_l, last_l;

  bit qm[$];
  bit ql[$];
  int total = 0;
  int bad = 0;

  seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(ready_m), .t(t_m), .t_valid(valid_m), .t_last(last_m)
  );

  seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(ready_l), .t(t_l), .t_valid(valid_l), .t_last(last_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic bm, bl;
    bm = 1'b0;
    bl = 1'b0;
    if (qm.size() > 0) bm = qm[0];
    if (ql.size() > 0) bl = ql[0];
    chk("msb_t_valid",   valid_m, qm.size() > 0);
    chk("msb_t",         t_m,     bm);
    chk("msb_t_last",    last_m,  qm.size() == 1);
    chk("msb_din_ready", ready_m, qm.size() <= 1);
    chk("lsb_t_valid",   valid_l, ql.size() > 0);
    chk("lsb_t",         t_l,     bl);
    chk("lsb_t_last",    last_l,  ql.size() == 1);
    chk("lsb_din_ready", ready_l, ql.size() <= 1);
  endtask

  task automatic push_frame(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) qm.push_back(d[i]);
    for (int i = 0; i < W; i++) ql.push_back(d[i]);
`ifdef SEQ_SER_PARITY_EN
    qm.push_back(^d);
    ql.push_back(^d);
`endif
  endtask

  // One clock cycle: drive inputs just after the falling edge, check, then
  // advance the model across the rising edge.
  task automatic step(input logic v, input logic [W-1:0] d);
    bit accept;
    din_valid = v;
    din = d;
    #1;
    check_outputs();
    accept = v && (qm.size() <= 1);
    @(posedge clk);
    if (qm.size() > 0) void'(qm.pop_front());
    if (ql.size() > 0) void'(ql.pop_front());
    if (accept) push_frame(d);
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom));
  endtask

  initial begin
    // Reset state before any clock edge
    #2;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Single frame A5 on the first edge after reset release
    step(1'b1, 8'hA5);
    idle_steps(11);

    // 0A: LSB-first 0,1,0,1,0,0,0,0 and MSB-first 0,0,0,0,1,0,1,0
    step(1'b1, 8'h0A);
    idle_steps(11);

    // Valid held high: A5 then 0F back to back
    step(1'b1, 8'hA5);
    for (int i = 0; i < 20; i++) step(1'b1, 8'h0F);
    idle_steps(4);

    // FF offered mid-frame must be ignored
    step(1'b1, 8'hA5);
    step(1'b0, 8'h00);
    for (int i = 0; i < 6; i++) step(1'b1, 8'hFF);
    idle_steps(6);

    // Asynchronous reset in the fourth cycle of a frame
    step(1'b1, 8'hA5);
    idle_steps(3);
    rst_n = 1'b0;
    #1;
    qm.delete();
    ql.delete();
    check_outputs();
    din_valid = 1'b1;
    din = 8'h99;
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h3C);
    idle_steps(11);

    // Random traffic with din changing every cycle
    for (int i = 0; i < 400; i++) step(1'($urandom_range(0, 2) != 0), W'($urandom));
    idle_steps(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
